// File: rtl/idecode_queue_pkg.sv
// Shared RV32I decode types: opcode encoding and the decoded-instruction record
// carried through the decode queue.
package idecode_queue_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    opcode_t                   opcode;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [2:0]                f3;
    logic [6:0]                f7;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      illegal;
  } decoded_instr_t;

endpackage

// File: rtl/idecode_queue_comb.sv
// Pure combinational RV32I field extraction and illegal-encoding detection.
// Fields a format does not use are left at zero; an illegal word keeps only
// its pc and raw opcode bits.
module idecode_comb
  import idecode_queue_pkg::*;
#(
  parameter int CHECK_ILLEGAL = 1
) (
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] pc,
  output decoded_instr_t        dec
);

  opcode_t            op;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;

  assign op    = opcode_t'(instr[6:0]);
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Per-format field selection, then collapse to an illegal record if needed.
  always_comb begin
    logic bad;
    bad        = 1'b0;
    dec        = '0;
    dec.pc     = pc;
    dec.opcode = op;
    case (op)
      OP_REG: begin
        dec.rd  = instr[11:7];
        dec.f3  = f3;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.f7  = f7;
        bad     = !((f7 == 7'h00) ||
                    ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
        dec.rd  = instr[11:7];
        dec.f3  = f3;
        dec.rs1 = instr[19:15];
        dec.f7  = f7;
        dec.imm = DATA_WIDTH'(imm_i);
        if (op == OP_IMM)
          bad = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
        else if (op == OP_LOAD)
          bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        else if (op == OP_JALR)
          bad = (f3 != 3'd0);
      end
      OP_STORE: begin
        dec.f3  = f3;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.imm = DATA_WIDTH'(imm_s);
        bad     = (f3 > 3'd2);
      end
      OP_BRANCH: begin
        dec.f3  = f3;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.imm = DATA_WIDTH'(imm_b);
        bad     = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OP_JAL: begin
        dec.rd  = instr[11:7];
        dec.imm = DATA_WIDTH'(imm_j);
      end
      OP_LUI, OP_AUIPC: begin
        dec.rd  = instr[11:7];
        dec.imm = {instr[31:12], 12'b0};
      end
      default: bad = 1'b1;
    endcase
    if ((CHECK_ILLEGAL != 0) && bad) begin
      dec         = '0;
      dec.pc      = pc;
      dec.opcode  = op;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/idecode_queue.sv
// Decode queue: instructions are decoded on entry and held in a DEPTH-entry
// FIFO of decoded records. in_ready depends only on occupancy; flush and
// reset empty the queue, the storage array itself is never cleared.
module idecode_queue
  import idecode_queue_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int CHECK_ILLEGAL = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_instr,
  input  logic [DATA_WIDTH-1:0]         in_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_pc,
  output opcode_t                       out_opcode,
  output logic [REG_ADDR_WIDTH-1:0]     out_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0]     out_rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0]     out_rd_addr,
  output logic [2:0]                    out_funct3,
  output logic [6:0]                    out_funct7,
  output logic [DATA_WIDTH-1:0]         out_imm,
  output logic                          out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  decoded_instr_t        dec_tail;
  decoded_instr_t        head;
  decoded_instr_t        mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  push;
  logic                  pop;

  idecode_comb #(
    .CHECK_ILLEGAL(CHECK_ILLEGAL)
  ) u_decode (
    .instr(in_instr),
    .pc   (in_pc),
    .dec  (dec_tail)
  );

  assign full      = (count == CW'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Control state: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Decoded-record storage, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= dec_tail;
  end

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign out_pc       = head.pc;
  assign out_opcode   = head.opcode;
  assign out_rs1_addr = head.rs1;
  assign out_rs2_addr = head.rs2;
  assign out_rd_addr  = head.rd;
  assign out_funct3   = head.f3;
  assign out_funct7   = head.f7;
  assign out_imm      = head.imm;
  assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_idecode_queue.sv
// Bench for idecode_queue: two instances (illegal checking on and off) share
// stimulus and are compared every cycle against a queue-based reference.
module tb_idecode_queue;
  import idecode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_pc, a_out_imm;
  opcode_t     a_out_opcode;
  logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd;
  logic [2:0]  a_out_f3;
  logic [6:0]  a_out_f7;
  logic [CW-1:0] a_count;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_pc, b_out_imm;
  opcode_t     b_out_opcode;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
  logic [2:0]  b_out_f3;
  logic [6:0]  b_out_f7;
  logic [CW-1:0] b_count;

  idecode_queue #(.DEPTH(DEPTH), .CHECK_ILLEGAL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_opcode(a_out_opcode), .out_rs1_addr(a_out_rs1), .out_rs2_addr(a_out_rs2),
    .out_rd_addr(a_out_rd), .out_funct3(a_out_f3), .out_funct7(a_out_f7),
    .out_imm(a_out_imm), .out_illegal(a_out_illegal), .count(a_count)
  );

  idecode_queue #(.DEPTH(DEPTH), .CHECK_ILLEGAL(0)) u_dut_nochk (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_opcode(b_out_opcode), .out_rs1_addr(b_out_rs1), .out_rs2_addr(b_out_rs2),
    .out_rd_addr(b_out_rd), .out_funct3(b_out_f3), .out_funct7(b_out_f7),
    .out_imm(b_out_imm), .out_illegal(b_out_illegal), .count(b_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  decoded_instr_t q_chk[$];
  decoded_instr_t q_nochk[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode from the instruction-format rules, using integer arithmetic.
  function automatic decoded_instr_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                                input bit chk_ill);
    decoded_instr_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    bit bad;
    int fmt;
    int v;
    f3  = w[14:12];
    f7  = w[31:25];
    bad = 0;
    fmt = 0;
    v   = 0;
    case (w[6:0])
      7'h33: begin fmt = 1; bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))); end
      7'h13: begin fmt = 2; bad = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 7'h20)); end
      7'h03: begin fmt = 2; bad = f3 inside {3, 6, 7}; end
      7'h67: begin fmt = 2; bad = (f3 != 0); end
      7'h0F, 7'h73: fmt = 2;
      7'h23: begin fmt = 3; bad = (f3 > 2); end
      7'h63: begin fmt = 4; bad = f3 inside {2, 3}; end
      7'h6F: fmt = 5;
      7'h37, 7'h17: fmt = 6;
      default: bad = 1;
    endcase
    d = '0;
    d.pc = pc;
    d.opcode = opcode_t'(w[6:0]);
    if (bad && chk_ill) begin
      d.illegal = 1'b1;
      return d;
    end
    case (fmt)
      1: begin d.rd = w[11:7]; d.f3 = f3; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f7 = f7; end
      2: begin
        d.rd = w[11:7]; d.f3 = f3; d.rs1 = w[19:15]; d.f7 = f7;
        v = int'(w[31:20]);
        if (v >= 2048) v -= 4096;
        d.imm = v;
      end
      3: begin
        d.f3 = f3; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        v = int'(w[31:25]) * 32 + int'(w[11:7]);
        if (v >= 2048) v -= 4096;
        d.imm = v;
      end
      4: begin
        d.f3 = f3; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192;
        d.imm = v;
      end
      5: begin
        d.rd = w[11:7];
        v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * (1 << 12) + int'(w[20]) * (1 << 11)
            + int'(w[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
        d.imm = v;
      end
      6: begin d.rd = w[11:7]; d.imm = w & 32'hFFFF_F000; end
      default: ;
    endcase
    return d;
  endfunction

  task automatic check_all();
    decoded_instr_t ea, eb;
    ea = (q_chk.size() > 0) ? q_chk[0] : '0;
    eb = (q_nochk.size() > 0) ? q_nochk[0] : '0;
    check_val("a_valid", a_out_valid, q_chk.size() > 0);
    check_val("a_ready", a_in_ready, q_chk.size() < DEPTH);
    check_val("a_count", a_count, q_chk.size());
    check_val("a_pc", a_out_pc, ea.pc);
    check_val("a_opcode", a_out_opcode, ea.opcode);
    check_val("a_rs1", a_out_rs1, ea.rs1);
    check_val("a_rs2", a_out_rs2, ea.rs2);
    check_val("a_rd", a_out_rd, ea.rd);
    check_val("a_f3", a_out_f3, ea.f3);
    check_val("a_f7", a_out_f7, ea.f7);
    check_val("a_imm", a_out_imm, ea.imm);
    check_val("a_illegal", a_out_illegal, ea.illegal);
    check_val("b_valid", b_out_valid, q_nochk.size() > 0);
    check_val("b_ready", b_in_ready, q_nochk.size() < DEPTH);
    check_val("b_count", b_count, q_nochk.size());
    check_val("b_pc", b_out_pc, eb.pc);
    check_val("b_opcode", b_out_opcode, eb.opcode);
    check_val("b_rs1", b_out_rs1, eb.rs1);
    check_val("b_rs2", b_out_rs2, eb.rs2);
    check_val("b_rd", b_out_rd, eb.rd);
    check_val("b_f3", b_out_f3, eb.f3);
    check_val("b_f7", b_out_f7, eb.f7);
    check_val("b_imm", b_out_imm, eb.imm);
    check_val("b_illegal", b_out_illegal, eb.illegal);
  endtask

  task automatic drive(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock: model decides push/pop from the current inputs, then compares.
  task automatic step();
    bit push, pop;
    push = in_valid && (q_chk.size() < DEPTH) && !flush;
    pop  = (q_chk.size() > 0) && out_ready && !flush;
    @(posedge clk);
    if (flush) begin
      q_chk.delete();
      q_nochk.delete();
    end else begin
      if (pop) begin
        void'(q_chk.pop_front());
        void'(q_nochk.pop_front());
      end
      if (push) begin
        q_chk.push_back(ref_decode(in_instr, in_pc, 1));
        q_nochk.push_back(ref_decode(in_instr, in_pc, 0));
      end
    end
    #1;
    check_all();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops [11];
    logic [31:0] w;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    w = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      w[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1)
        w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  initial begin
    // Reset state
    #2;
    check_all();
    #10 rst_n = 1'b1;

    // ADDI x1,x2,-1 into an empty queue
    drive(1, 32'hFFF1_0093, 32'h100, 0, 0);
    step();
    check_val("addi_valid", a_out_valid, 1);
    check_val("addi_rd", a_out_rd, 1);
    check_val("addi_rs1", a_out_rs1, 2);
    check_val("addi_f3", a_out_f3, 0);
    check_val("addi_imm", a_out_imm, 32'hFFFF_FFFF);
    check_val("addi_illegal", a_out_illegal, 0);
    check_val("addi_count", a_count, 1);
    drive(0, 0, 0, 1, 0);
    step();

    // Fill past capacity with the consumer stalled, then drain in order
    for (int i = 0; i < 5; i++) begin
      drive(1, gen_instr(), 32'h200 + 4 * i, 0, 0);
      step();
      if (i == 3) check_val("full_ready", a_in_ready, 0);
    end
    check_val("full_count", a_count, 4);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      check_val("drain_pc", a_out_pc, 32'h200 + 4 * i);
      step();
    end
    check_val("drain_empty", a_out_valid, 0);

    // Continuous streaming: one per cycle at occupancy 1
    for (int i = 0; i < 20; i++) begin
      drive(1, gen_instr(), 32'h1000 + 4 * i, 1, 0);
      step();
      check_val("stream_count", a_count, 1);
    end
    drive(0, 0, 0, 1, 0);
    step();

    // Illegal encodings
    drive(1, 32'h0000_0000, 32'h300, 0, 0);
    step();
    drive(1, 32'h0000_B083, 32'h304, 0, 0);
    step();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      check_val("ill_a", a_out_illegal, 1);
      check_val("ill_imm", a_out_imm, 0);
      check_val("ill_b", b_out_illegal, 0);
      step();
    end

    // Flush with a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1, gen_instr(), 32'h400 + 4 * i, 0, 0);
      step();
    end
    drive(1, 32'h0010_0093, 32'h40C, 1, 1);
    step();
    check_val("flush_count", a_count, 0);
    check_val("flush_valid", a_out_valid, 0);
    drive(0, 0, 0, 0, 0);
    step();

    // Asynchronous reset between edges
    drive(1, 32'h0010_0093, 32'h500, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    q_chk.delete();
    q_nochk.delete();
    check_val("rst_valid", a_out_valid, 0);
    check_val("rst_count", a_count, 0);
    check_all();
    #2 rst_n = 1'b1;
    drive(1, 32'h0080_00EF, 32'h600, 0, 0);
    step();
    check_val("jal_imm", a_out_imm, 8);
    check_val("jal_rd", a_out_rd, 1);
    drive(0, 0, 0, 1, 0);
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
